// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner with debounce. Codes (row*4+col) leave through a valid/ack handshake.
// Define KEYPAD_REPEAT_EN to re-accept a held key every REPEAT_SAMPLES samples.
module keypad_scan_encoder #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_CNT   = 3,
  parameter int REPEAT_SAMPLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] cod,
  output logic       cod_valid,
  input  logic       cod_ack,
  output logic       overrun
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       row_meta_reg, row_sync_reg;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [1:0]       col_idx_reg, col_idx_next;
  logic [1:0]       key_row_reg, key_row_next;
  logic [DEB_W-1:0] match_cnt_reg, match_cnt_next;
  logic [DEB_W-1:0] rel_cnt_reg, rel_cnt_next;
  logic [3:0]       cod_reg, cod_next;
  logic             cod_valid_reg, cod_valid_next;
  logic             overrun_reg, overrun_next;
  logic             sample, single_low, all_high, same_key, accept;
  logic [1:0]       low_idx;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SAMPLES + 1);
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
`endif

  assign sample     = (div_cnt_reg == DIV_W'(SCAN_DIV - 1));
  assign single_low = $onehot(~row_sync_reg);
  assign all_high   = (row_sync_reg == 4'hF);
  assign same_key   = single_low && (low_idx == key_row_reg);

  always_comb begin
    low_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row_sync_reg[i]) low_idx = 2'(i);
    end
  end

  // State register, including the two-flop row synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= SCAN;
      row_meta_reg  <= 4'hF;
      row_sync_reg  <= 4'hF;
      div_cnt_reg   <= '0;
      col_idx_reg   <= 2'd0;
      key_row_reg   <= 2'd0;
      match_cnt_reg <= '0;
      rel_cnt_reg   <= '0;
      cod_reg       <= 4'd0;
      cod_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      row_meta_reg  <= row;
      row_sync_reg  <= row_meta_reg;
      div_cnt_reg   <= div_cnt_next;
      col_idx_reg   <= col_idx_next;
      key_row_reg   <= key_row_next;
      match_cnt_reg <= match_cnt_next;
      rel_cnt_reg   <= rel_cnt_next;
      cod_reg       <= cod_next;
      cod_valid_reg <= cod_valid_next;
      overrun_reg   <= overrun_next;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg   <= rep_cnt_next;
`endif
    end
  end

  // Next-state: all decisions are taken only on the sample clock of a slot
  always_comb begin
    state_next     = state_reg;
    div_cnt_next   = sample ? '0 : div_cnt_reg + DIV_W'(1);
    col_idx_next   = col_idx_reg;
    key_row_next   = key_row_reg;
    match_cnt_next = match_cnt_reg;
    rel_cnt_next   = rel_cnt_reg;
    accept         = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_next   = rep_cnt_reg;
`endif
    if (sample) begin
      case (state_reg)
        SCAN: begin
          if (single_low) begin
            key_row_next   = low_idx;
            match_cnt_next = DEB_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              accept       = 1'b1;
              state_next   = HOLD;
              rel_cnt_next = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_next = '0;
`endif
            end else begin
              state_next = DEBOUNCE;
            end
          end else begin
            col_idx_next = col_idx_reg + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (same_key) begin
            match_cnt_next = match_cnt_reg + DEB_W'(1);
            if (match_cnt_reg == DEB_W'(DEBOUNCE_CNT - 1)) begin
              accept       = 1'b1;
              state_next   = HOLD;
              rel_cnt_next = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_next = '0;
`endif
            end
          end else begin
            state_next     = SCAN;
            col_idx_next   = col_idx_reg + 2'd1;
            match_cnt_next = '0;
          end
        end
        HOLD: begin
          if (all_high) begin
            rel_cnt_next = rel_cnt_reg + DEB_W'(1);
            if (rel_cnt_reg == DEB_W'(DEBOUNCE_CNT - 1)) begin
              state_next     = SCAN;
              col_idx_next   = col_idx_reg + 2'd1;
              rel_cnt_next   = '0;
              match_cnt_next = '0;
            end
          end else begin
            rel_cnt_next = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (same_key) begin
            if (rep_cnt_reg == REP_W'(REPEAT_SAMPLES - 1)) begin
              accept       = 1'b1;
              rep_cnt_next = '0;
            end else begin
              rep_cnt_next = rep_cnt_reg + REP_W'(1);
            end
          end else begin
            rep_cnt_next = '0;
          end
`endif
        end
        default: state_next = SCAN;
      endcase
    end
  end

  // Output handshake: an ack in the accept cycle frees the slot for the new code
  always_comb begin
    cod_next       = cod_reg;
    cod_valid_next = cod_valid_reg;
    overrun_next   = overrun_reg;
    if (accept) begin
      if (!cod_valid_reg || cod_ack) begin
        cod_next       = {key_row_next, col_idx_reg};
        cod_valid_next = 1'b1;
        if (cod_ack) overrun_next = 1'b0;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (cod_ack && cod_valid_reg) begin
      cod_valid_next = 1'b0;
      overrun_next   = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign col[gi] = (col_idx_reg != 2'(gi));
    end
  endgenerate

  assign cod       = cod_reg;
  assign cod_valid = cod_valid_reg;
  assign overrun   = overrun_reg;
endmodule
